// File: rtl/dec5421_pkg.sv
// Shared definitions for the sequential 5421-coded decimal multiplier:
// state encoding, 5421 bit weights, illegal-code table and digit width.
package dec5421_pkg;

   localparam int DW = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PRE  = 2'd1,
      ACC  = 2'd2,
      DONE = 2'd3
   } state_t;

   // Decimal weight of each 5421 code bit, indexed by bit position.
   localparam int unsigned WEIGHT [4] = '{1, 2, 4, 5};

   localparam logic [DW-1:0] ILLEGAL_CODES [6] = '{
      4'b0101, 4'b0110, 4'b0111, 4'b1101, 4'b1110, 4'b1111
   };

   function automatic logic is_illegal_5421(input logic [DW-1:0] d);
      logic hit;
      hit = 1'b0;
      for (int j = 0; j < 6; j++) begin
         if (d == ILLEGAL_CODES[j]) hit = 1'b1;
      end
      return hit;
   endfunction

endpackage

// File: rtl/dec5421_seq_multiplier_bcd_digit_add.sv
// Single-digit BCD adder with +6 correction; the building block for every
// decimal add in the multiplier (multiple generation and accumulation).
module bcd_digit_add
   import dec5421_pkg::*;
(
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   input  logic          cin,
   output logic [DW-1:0] s,
   output logic          cout
);

   logic [DW:0] raw;

   // NOTE: every output of a combinational block gets a value on every path,
   // otherwise synthesis infers a latch to hold the old value.
   always_comb begin
      raw  = {1'b0, a} + {1'b0, b} + {{DW{1'b0}}, cin};
      cout = (raw > (DW+1)'(9));
      s    = cout ? DW'(raw + (DW+1)'(6)) : raw[DW-1:0];
   end

endmodule

// File: rtl/dec5421_seq_multiplier.sv
// Sequential N x N digit decimal multiplier: multiplier in 5421 code, multiplicand
// and product in BCD-8421; one selected multiple (5A/4A/2A/A) accumulated per cycle.
module dec5421_seq_multiplier
   import dec5421_pkg::*;
#(
   parameter int N = 4
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DW*N-1:0]   a_bcd,
   input  logic [DW*N-1:0]   b_5421,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [2*DW*N-1:0] p_bcd,
   output logic              code_err
);

   localparam int MW = DW * (N + 1);
   localparam int AW = 2 * DW * N;
   localparam int IW = (N > 1) ? $clog2(N) : 1;

   state_t            state, state_nxt;
   logic [DW*N-1:0]   a_q, b_q;
   logic [MW-1:0]     m1_q, m2_q, m4_q, m5_q;
   logic [MW-1:0]     m2_c, m4_c, m5_c;
   logic [AW-1:0]     acc_q, acc_sum, addend;
   logic [MW-1:0]     mult_sel;
   logic [IW-1:0]     i_q;
   logic [1:0]        k_q;
   logic              err_q;
   logic              last_step;
   logic              any_illegal;
   logic [DW-1:0]     b_dig [N];

   // Digit-local doubling chains give 2A and 4A; 5A is 4A + A.
   for (genvar d = 0; d < N; d++) begin : g_mul
      logic c2_in, c4_in, c5_in, c2_out, c4_out, c5_out;
      if (d == 0) begin : g_lsd
         assign c2_in = 1'b0;
         assign c4_in = 1'b0;
         assign c5_in = 1'b0;
      end else begin : g_nxt
         assign c2_in = g_mul[d-1].c2_out;
         assign c4_in = g_mul[d-1].c4_out;
         assign c5_in = g_mul[d-1].c5_out;
      end
      bcd_digit_add u_dbl (.a(a_q[d*DW +: DW]), .b(a_q[d*DW +: DW]), .cin(c2_in),
                           .s(m2_c[d*DW +: DW]), .cout(c2_out));
      bcd_digit_add u_quad (.a(m2_c[d*DW +: DW]), .b(m2_c[d*DW +: DW]), .cin(c4_in),
                            .s(m4_c[d*DW +: DW]), .cout(c4_out));
      bcd_digit_add u_five (.a(m4_c[d*DW +: DW]), .b(a_q[d*DW +: DW]), .cin(c5_in),
                            .s(m5_c[d*DW +: DW]), .cout(c5_out));
      assign b_dig[d] = b_q[d*DW +: DW];
   end

   // Top digits stay small (2A <= 1.., 4A <= 3.., 5A <= 4..), so binary adds suffice there.
   assign m2_c[MW-1 -: DW] = {{(DW-1){1'b0}}, g_mul[N-1].c2_out};
   assign m4_c[MW-1 -: DW] = {{(DW-2){1'b0}}, g_mul[N-1].c2_out, g_mul[N-1].c4_out};
   assign m5_c[MW-1 -: DW] = m4_c[MW-1 -: DW] + {{(DW-1){1'b0}}, g_mul[N-1].c5_out};

   always_comb begin
      mult_sel = m1_q;
      case (WEIGHT[k_q])
         5:       mult_sel = m5_q;
         4:       mult_sel = m4_q;
         2:       mult_sel = m2_q;
         default: mult_sel = m1_q;
      endcase
      addend = b_dig[i_q][k_q] ? (AW'(mult_sel) << (DW * i_q)) : '0;
   end

   // Accumulator never exceeds 10^(2N)-1, so the top carry-out carries no information.
   for (genvar d = 0; d < 2*N; d++) begin : g_acc
      logic cin, cout;
      if (d == 0) begin : g_lsd
         assign cin = 1'b0;
      end else begin : g_nxt
         assign cin = g_acc[d-1].cout;
      end
      bcd_digit_add u_add (.a(acc_q[d*DW +: DW]), .b(addend[d*DW +: DW]), .cin(cin),
                           .s(acc_sum[d*DW +: DW]), .cout(cout));
   end

   always_comb begin
      any_illegal = 1'b0;
      for (int d = 0; d < N; d++) begin
         if (is_illegal_5421(b_5421[d*DW +: DW])) any_illegal = 1'b1;
      end
   end

   assign last_step = (i_q == IW'(N-1)) && (k_q == 2'd0);

   // NOTE: clocked state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid)  state_nxt = PRE;
         PRE:                    state_nxt = ACC;
         ACC:     if (last_step) state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default:                state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q   <= '0;
         b_q   <= '0;
         m1_q  <= '0;
         m2_q  <= '0;
         m4_q  <= '0;
         m5_q  <= '0;
         acc_q <= '0;
         err_q <= 1'b0;
         i_q   <= '0;
         k_q   <= '0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               a_q   <= a_bcd;
               b_q   <= b_5421;
               acc_q <= '0;
               err_q <= any_illegal;
            end
            PRE: begin
               m1_q <= MW'(a_q);
               m2_q <= m2_c;
               m4_q <= m4_c;
               m5_q <= m5_c;
               i_q  <= '0;
               k_q  <= 2'd3;
            end
            ACC: begin
               acc_q <= acc_sum;
               if (k_q == 2'd0) begin
                  i_q <= i_q + IW'(1);
                  k_q <= 2'd3;
               end else begin
                  k_q <= k_q - 2'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign p_bcd    = acc_q;
   assign code_err = err_q;

endmodule
